// File: rtl/reg_writeback_pkg.sv
// Shared constants for the register write-back slice.
// Optional forwarding path is enabled by defining REG_WB_FWD_EN.
package reg_writeback_pkg;

  localparam int unsigned RWB_NUM_REGS = 16;
  localparam int unsigned RWB_ZERO_REG = 0;
  localparam int unsigned RWB_ADDR_W   = $clog2(RWB_NUM_REGS);
  localparam int unsigned RWB_DATA_W   = 32;
  localparam int unsigned RWB_DEPTH    = 4;

endpackage

// File: rtl/reg_writeback_if.sv
// Producer / register-bank / hazard-check bundle for reg_writeback.
// slave = the write-back unit, master = the surrounding pipeline.
interface reg_writeback_if
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH  = RWB_DEPTH,
  parameter int unsigned DATA_W = RWB_DATA_W,
  parameter int unsigned ADDR_W = RWB_ADDR_W
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic              in_valid;
  logic              in_ready;
  logic [ADDR_W-1:0] in_rd;
  logic [DATA_W-1:0] in_data;
  logic              flush;
  logic              wb_stall;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_rd;
  logic [DATA_W-1:0] wr_data;
  logic [ADDR_W-1:0] rs;
  logic [ADDR_W-1:0] rt;
  logic              rs_busy;
  logic              rt_busy;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] rs_fwd_data;
  logic [DATA_W-1:0] rt_fwd_data;

  modport slave (
    input  in_valid, in_rd, in_data, flush, wb_stall, rs, rt,
    output in_ready, wr_en, wr_rd, wr_data, rs_busy, rt_busy, count,
           rs_fwd_data, rt_fwd_data
  );

  modport master (
    output in_valid, in_rd, in_data, flush, wb_stall, rs, rt,
    input  in_ready, wr_en, wr_rd, wr_data, rs_busy, rt_busy, count,
           rs_fwd_data, rt_fwd_data
  );

endinterface

// File: rtl/reg_writeback_wb_fifo.sv
// Pending-write queue: storage, head/tail pointers and occupancy count.
// Exposes entries in age order (index 0 = head) for hazard matching.
// Entry data in age order is only exported when REG_WB_FWD_EN is defined.
module wb_fifo
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH  = RWB_DEPTH,
  parameter int unsigned DATA_W = RWB_DATA_W,
  parameter int unsigned ADDR_W = RWB_ADDR_W,
  parameter int unsigned CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          push_i,
  input  logic                          pop_i,
  input  logic                          flush_i,
  input  logic [ADDR_W-1:0]             push_rd_i,
  input  logic [DATA_W-1:0]             push_data_i,
  output logic [DATA_W-1:0]             head_data_o,
  output logic [DEPTH-1:0][ADDR_W-1:0]  ord_rd_o,
`ifdef REG_WB_FWD_EN
  output logic [DEPTH-1:0][DATA_W-1:0]  ord_data_o,
`endif
  output logic [DEPTH-1:0]              ord_valid_o,
  output logic [CNT_W-1:0]              count_o
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DEPTH-1:0][ADDR_W-1:0] rd_mem_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_mem_q;
  logic [PW-1:0]                head_q, head_d;
  logic [PW-1:0]                tail_q, tail_d;
  logic [CNT_W-1:0]             count_q, count_d;

  // Next pointer/count state; flush overrides any push or pop.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush_i) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_i) tail_d = tail_q + 1'b1;
      if (pop_i)  head_d = head_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and count registers, cleared asynchronously.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage; not reset, validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (push_i) begin
      rd_mem_q[tail_q]   <= push_rd_i;
      data_mem_q[tail_q] <= push_data_i;
    end
  end

  // Rotate storage into age order, oldest first.
  always_comb begin
    logic [PW-1:0] idx;
    idx         = '0;
    ord_rd_o    = '0;
    ord_valid_o = '0;
`ifdef REG_WB_FWD_EN
    ord_data_o  = '0;
`endif
    for (int unsigned k = 0; k < DEPTH; k++) begin
      idx            = head_q + PW'(k);
      ord_rd_o[k]    = rd_mem_q[idx];
      ord_valid_o[k] = CNT_W'(k) < count_q;
`ifdef REG_WB_FWD_EN
      ord_data_o[k]  = data_mem_q[idx];
`endif
    end
  end

  assign head_data_o = data_mem_q[head_q];
  assign count_o     = count_q;

endmodule

// File: rtl/reg_writeback.sv
// Register write-back unit: queues producer results and drains them to the
// register bank in order, with hazard flags for two source operands.
// Define REG_WB_FWD_EN to forward the youngest pending value per source.
module reg_writeback
  import reg_writeback_pkg::*;
#(
  parameter int unsigned DEPTH  = RWB_DEPTH,
  parameter int unsigned DATA_W = RWB_DATA_W,
  parameter int unsigned ADDR_W = RWB_ADDR_W
) (
  input logic           clk,
  input logic           reset,
  reg_writeback_if.slave bus
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] ZERO_RD = ADDR_W'(RWB_ZERO_REG);

  logic                         ready;
  logic                         push;
  logic                         pop;
  logic [CNT_W-1:0]             count;
  logic [DATA_W-1:0]            head_data;
  logic [DEPTH-1:0][ADDR_W-1:0] ord_rd;
  logic [DEPTH-1:0]             ord_valid;
  logic                         rs_busy;
  logic                         rt_busy;
  logic [DATA_W-1:0]            rs_fwd;
  logic [DATA_W-1:0]            rt_fwd;
`ifdef REG_WB_FWD_EN
  logic [DEPTH-1:0][DATA_W-1:0] ord_data;
`endif

  // Ready ignores a same-cycle pop so a full queue always refuses.
  assign ready = count < CNT_W'(DEPTH);
  // Writes to the zero register complete the handshake but are dropped.
  assign push  = bus.in_valid && ready && (bus.in_rd != ZERO_RD);
  assign pop   = (count != '0) && !bus.wb_stall && !bus.flush;

  wb_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (bus.flush),
    .push_rd_i   (bus.in_rd),
    .push_data_i (bus.in_data),
    .head_data_o (head_data),
    .ord_rd_o    (ord_rd),
`ifdef REG_WB_FWD_EN
    .ord_data_o  (ord_data),
`endif
    .ord_valid_o (ord_valid),
    .count_o     (count)
  );

  // Busy when any stored entry targets the source (never for R0).
  always_comb begin
    rs_busy = 1'b0;
    rt_busy = 1'b0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ord_valid[k] && (bus.rs != ZERO_RD) && (ord_rd[k] == bus.rs)) rs_busy = 1'b1;
      if (ord_valid[k] && (bus.rt != ZERO_RD) && (ord_rd[k] == bus.rt)) rt_busy = 1'b1;
    end
  end

`ifdef REG_WB_FWD_EN
  // Scan oldest to youngest so the last match (youngest) wins.
  always_comb begin
    rs_fwd = '0;
    rt_fwd = '0;
    for (int unsigned k = 0; k < DEPTH; k++) begin
      if (ord_valid[k] && (bus.rs != ZERO_RD) && (ord_rd[k] == bus.rs)) rs_fwd = ord_data[k];
      if (ord_valid[k] && (bus.rt != ZERO_RD) && (ord_rd[k] == bus.rt)) rt_fwd = ord_data[k];
    end
  end
`else
  assign rs_fwd = '0;
  assign rt_fwd = '0;
`endif

  assign bus.in_ready    = ready;
  assign bus.wr_en       = pop;
  assign bus.wr_rd       = ord_rd[0];
  assign bus.wr_data     = head_data;
  assign bus.rs_busy     = rs_busy;
  assign bus.rt_busy     = rt_busy;
  assign bus.count       = count;
  assign bus.rs_fwd_data = rs_fwd;
  assign bus.rt_fwd_data = rt_fwd;

endmodule

// File: tb/tb_reg_writeback.sv
// Testbench for reg_writeback: vector table, directed corner sequences and a
// random phase, all cross-checked by a queue-based scoreboard monitor.
module tb_reg_writeback;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 4;

  logic clk;
  logic reset;

  reg_writeback_if #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) bus ();

  reg_writeback #(.DEPTH(DEPTH), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors;
  int miscompares;

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  // ---------------- scoreboard monitor ----------------
  typedef struct {
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
  } ent_t;

  ent_t sb[$];
  int            n;
  logic          e_wen, e_rdy, e_rsb, e_rtb;
  logic [DW-1:0] e_rsf, e_rtf;
  ent_t          e_new;

  always @(posedge reset) sb.delete();

  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
      chk("rst_wr_en",   bus.wr_en, 0);
      chk("rst_ready",   bus.in_ready, 1);
      chk("rst_count",   bus.count, 0);
      chk("rst_busy",    {bus.rs_busy, bus.rt_busy}, 0);
      chk("rst_fwd",     {bus.rs_fwd_data, bus.rt_fwd_data}, 0);
    end else begin
      n     = sb.size();
      e_rdy = (n < DEPTH);
      e_wen = (n != 0) && !bus.wb_stall && !bus.flush;
      e_rsb = 1'b0; e_rtb = 1'b0; e_rsf = '0; e_rtf = '0;
      for (int i = 0; i < n; i++) begin
        if (bus.rs != 0 && sb[i].rd == bus.rs) begin e_rsb = 1'b1; e_rsf = sb[i].data; end
        if (bus.rt != 0 && sb[i].rd == bus.rt) begin e_rtb = 1'b1; e_rtf = sb[i].data; end
      end
`ifndef REG_WB_FWD_EN
      e_rsf = '0; e_rtf = '0;
`endif
      chk("sb_count",    bus.count, n);
      chk("sb_ready",    bus.in_ready, e_rdy);
      chk("sb_wr_en",    bus.wr_en, e_wen);
      chk("sb_rs_busy",  bus.rs_busy, e_rsb);
      chk("sb_rt_busy",  bus.rt_busy, e_rtb);
      chk("sb_rs_fwd",   bus.rs_fwd_data, e_rsf);
      chk("sb_rt_fwd",   bus.rt_fwd_data, e_rtf);
      if (n != 0) begin
        chk("sb_wr_rd",   bus.wr_rd, sb[0].rd);
        chk("sb_wr_data", bus.wr_data, sb[0].data);
      end
      if (bus.flush) begin
        sb.delete();
      end else begin
        if (e_wen) void'(sb.pop_front());
        if (bus.in_valid && e_rdy && bus.in_rd != 0) begin
          e_new.rd   = bus.in_rd;
          e_new.data = bus.in_data;
          sb.push_back(e_new);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  typedef struct {
    logic          v;
    logic [AW-1:0] rd;
    logic [DW-1:0] data;
    logic          stall;
    logic          flush;
    logic [AW-1:0] rs;
    logic [AW-1:0] rt;
    logic          e_wr_en;
    logic [AW-1:0] e_wr_rd;
    int            e_count;
    logic          e_ready;
    logic          e_rs_busy;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(input logic v, input int rd, input logic [DW-1:0] d,
                              input logic st, input logic fl, input int rs, input int rt,
                              input logic ewe, input int ewrd, input int ecnt,
                              input logic erdy, input logic ebusy);
    vec_t r;
    r.v = v; r.rd = AW'(rd); r.data = d; r.stall = st; r.flush = fl;
    r.rs = AW'(rs); r.rt = AW'(rt); r.e_wr_en = ewe; r.e_wr_rd = AW'(ewrd);
    r.e_count = ecnt; r.e_ready = erdy; r.e_rs_busy = ebusy;
    return r;
  endfunction

  // One cycle: drive just after the rising edge, return at the falling edge.
  task automatic step(input logic v, input logic [AW-1:0] rd, input logic [DW-1:0] d,
                      input logic st, input logic fl, input logic [AW-1:0] rs,
                      input logic [AW-1:0] rt);
    @(posedge clk);
    #1;
    bus.in_valid = v;
    bus.in_rd    = rd;
    bus.in_data  = d;
    bus.wb_stall = st;
    bus.flush    = fl;
    bus.rs       = rs;
    bus.rt       = rt;
    @(negedge clk);
  endtask

  logic [DW-1:0] exp_fwd;

  initial begin
    vectors = 0;
    miscompares = 0;
    reset = 1'b1;
    bus.in_valid = 1'b0; bus.in_rd = '0; bus.in_data = '0;
    bus.wb_stall = 1'b0; bus.flush = 1'b0; bus.rs = '0; bus.rt = '0;

    //           v  rd data          st fl rs rt  wen wrd cnt rdy busy
    tbl[0]  = mk(1, 3, 32'hAAAA0003, 0, 0, 3, 0,  0,  0,  0,  1,  0);
    tbl[1]  = mk(0, 0, 32'h0,        0, 0, 3, 0,  1,  3,  1,  1,  1);
    tbl[2]  = mk(1, 0, 32'hDEAD,     0, 0, 3, 0,  0,  0,  0,  1,  0);
    tbl[3]  = mk(0, 0, 32'h0,        0, 0, 3, 0,  0,  0,  0,  1,  0);
    tbl[4]  = mk(1, 1, 32'h1,        1, 0, 1, 0,  0,  0,  0,  1,  0);
    tbl[5]  = mk(1, 2, 32'h2,        1, 0, 1, 0,  0,  0,  1,  1,  1);
    tbl[6]  = mk(1, 3, 32'h3,        1, 0, 1, 0,  0,  0,  2,  1,  1);
    tbl[7]  = mk(1, 4, 32'h4,        1, 0, 1, 0,  0,  0,  3,  1,  1);
    tbl[8]  = mk(1, 5, 32'h55,       1, 0, 1, 0,  0,  0,  4,  0,  1);
    tbl[9]  = mk(1, 5, 32'h55,       0, 0, 1, 0,  1,  1,  4,  0,  1);
    tbl[10] = mk(1, 5, 32'h55,       0, 0, 1, 0,  1,  2,  3,  1,  0);
    tbl[11] = mk(0, 0, 32'h0,        0, 0, 1, 0,  1,  3,  3,  1,  0);
    tbl[12] = mk(0, 0, 32'h0,        0, 0, 1, 0,  1,  4,  2,  1,  0);
    tbl[13] = mk(0, 0, 32'h0,        0, 0, 1, 0,  1,  5,  1,  1,  0);
    tbl[14] = mk(0, 0, 32'h0,        0, 0, 1, 0,  0,  0,  0,  1,  0);

    repeat (2) @(posedge clk);
    #3 reset = 1'b0;

    // Table: single write latency, R0 drop, fill/hold/drain ordering.
    for (int i = 0; i < 15; i++) begin
      step(tbl[i].v, tbl[i].rd, tbl[i].data, tbl[i].stall, tbl[i].flush, tbl[i].rs, tbl[i].rt);
      chk($sformatf("tbl%0d_wr_en", i),   bus.wr_en, tbl[i].e_wr_en);
      chk($sformatf("tbl%0d_count", i),   bus.count, tbl[i].e_count);
      chk($sformatf("tbl%0d_ready", i),   bus.in_ready, tbl[i].e_ready);
      chk($sformatf("tbl%0d_rs_busy", i), bus.rs_busy, tbl[i].e_rs_busy);
      if (tbl[i].e_wr_en) chk($sformatf("tbl%0d_wr_rd", i), bus.wr_rd, tbl[i].e_wr_rd);
    end

    // Two pending writes to the same register: youngest is forwarded.
`ifdef REG_WB_FWD_EN
    exp_fwd = 32'h22;
`else
    exp_fwd = 32'h0;
`endif
    step(1, 5, 32'h11, 1, 0, 0, 0);
    step(1, 5, 32'h22, 1, 0, 0, 0);
    step(0, 0, 32'h0,  1, 0, 5, 5);
    chk("fwd_rs_busy", bus.rs_busy, 1);
    chk("fwd_rt_busy", bus.rt_busy, 1);
    chk("fwd_rs_data", bus.rs_fwd_data, exp_fwd);
    chk("fwd_rt_data", bus.rt_fwd_data, exp_fwd);
    step(0, 0, 32'h0,  1, 0, 0, 5);
    chk("fwd_r0_busy", bus.rs_busy, 0);
    chk("fwd_r0_data", bus.rs_fwd_data, 0);

    // Flush with a concurrent offer empties the queue and drops the offer.
    step(1, 7, 32'h77, 1, 0, 5, 0);
    step(1, 9, 32'h99, 0, 1, 5, 9);
    chk("flush_count_before", bus.count, 3);
    chk("flush_wr_en",        bus.wr_en, 0);
    chk("flush_ready",        bus.in_ready, 1);
    step(0, 0, 32'h0, 0, 0, 5, 9);
    chk("flush_count_after", bus.count, 0);
    chk("flush_wr_en_after", bus.wr_en, 0);
    chk("flush_busy_after",  {bus.rs_busy, bus.rt_busy}, 0);

    // Asynchronous reset while draining.
    step(1, 6, 32'h66, 1, 0, 0, 0);
    step(1, 8, 32'h88, 1, 0, 0, 0);
    step(0, 0, 32'h0,  0, 0, 6, 8);
    chk("arst_pre_wr_en", bus.wr_en, 1);
    chk("arst_pre_count", bus.count, 2);
    #2 reset = 1'b1;
    #1;
    chk("arst_wr_en",  bus.wr_en, 0);
    chk("arst_count",  bus.count, 0);
    chk("arst_busy",   {bus.rs_busy, bus.rt_busy}, 0);
    chk("arst_ready",  bus.in_ready, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 32'h0, 0, 0, 6, 8);
      chk($sformatf("arst_post%0d_wr_en", i), bus.wr_en, 0);
    end

    // Random traffic, checked by the scoreboard monitor.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 6)), $urandom,
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 31) == 0),
           AW'($urandom_range(0, 6)), AW'($urandom_range(0, 6)));
    end
    for (int i = 0; i < 8; i++) step(0, 0, 32'h0, 0, 0, 0, 0);
    chk("drain_count", bus.count, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/reg_writeback.md
REG_WRITEBACK -- requirements
Module: reg_writeback

Interface
REQ-001 Parameter DEPTH, default 4: pending-write queue entries; power of two, 2..16.
REQ-002 Parameter DATA_W, default 32: write-data width.
REQ-003 Parameter ADDR_W, default 4: register address width (R0..R15).
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 in_valid  input  1  producer offers a result.
REQ-007 in_ready  output  1  queue can accept; in_ready = (count < DEPTH).
REQ-008 in_rd  input  ADDR_W  destination register of offered result.
REQ-009 in_data  input  DATA_W  offered result value.
REQ-010 flush  input  1  synchronous discard of all pending writes.
REQ-011 wb_stall  input  1  register-bank port unavailable this cycle.
REQ-012 wr_en  output  1  register-bank write enable (drives wrReg).
REQ-013 wr_rd  output  ADDR_W  register-bank write address.
REQ-014 wr_data  output  DATA_W  register-bank write data.
REQ-015 rs, rt  input  ADDR_W each  source addresses under hazard check.
REQ-016 rs_busy, rt_busy  output  1 each  pending write exists for rs/rt.
REQ-017 count  output  $clog2(DEPTH)+1  number of queued entries.
REQ-018 rs_fwd_data, rt_fwd_data  output  DATA_W each  forwarded value (see Configuration).

Function
REQ-019 Handshake completes on a rising edge where in_valid && in_ready; in_ready does not depend on same-cycle pop (full queue refuses even while draining).
REQ-020 Accepted result with in_rd == 0 completes the handshake but is not enqueued; count unchanged.
REQ-021 Accepted result with in_rd != 0 is appended at tail; count increments.
REQ-022 wr_en = (count != 0) && !wb_stall && !flush; wr_rd/wr_data = head entry, combinational from queue state.
REQ-023 When wr_en is high the head entry is popped at that edge; count decrements.
REQ-024 Simultaneous push and pop: count unchanged, order preserved; strict FIFO order to the register bank.
REQ-025 Latency: result accepted at edge N into empty queue appears on wr_* during cycle N+1 (written at edge N+1 unless stalled); no same-cycle bypass from in_* to wr_*.
REQ-026 wb_stall holds head entry and all wr_* values except wr_en; no entry lost or duplicated.
REQ-027 flush empties queue at the edge it is sampled; flush has priority over push and pop in that cycle; in_ready stays (count < DEPTH) during flush, but an accepted item is discarded.
REQ-028 rs_busy = (rs != 0) && any valid entry has rd == rs; rt_busy likewise; combinational, stored entries only, not in_* of the current cycle.
REQ-029 Head/tail pointers wrap modulo DEPTH; count distinguishes full from empty.

Reset
REQ-030 reset clears head, tail and count to 0; wr_en = 0, in_ready = 1, rs_busy = rt_busy = 0, fwd outputs = 0.
REQ-031 reset mid-operation discards all pending writes; queue data storage is not required to be cleared.

Configuration
REQ-032 Macro REG_WB_FWD_EN defined: rs_fwd_data = data of youngest valid entry whose rd == rs, 0 when rs_busy = 0; rt_fwd_data likewise.
REQ-033 REG_WB_FWD_EN undefined: rs_fwd_data and rt_fwd_data tied to 0; no match-priority logic synthesized; all other behaviour identical.

Structure
REQ-034 Shared package holds ADDR_W/DATA_W defaults, register count (16) and zero-register index constant (0).
REQ-035 One sub-module, wb_fifo (storage, pointers, count); hazard/forward match logic stays in reg_writeback.

Verification
REQ-036 Reset, then push (rd=3, 0xAAAA0003) with wb_stall=0 -> next cycle wr_en=1, wr_rd=3, wr_data=0xAAAA0003; count back to 0 after that edge.
REQ-037 Push rd=0 data 0xDEAD -> handshake completes, count stays 0, wr_en never asserts.
REQ-038 wb_stall=1, push 4 entries (rd=1..4) -> count=4, in_ready=0; fifth offer held; release stall -> writes rd 1,2,3,4 on consecutive cycles, in_ready=1 after first pop.
REQ-039 Queue holds rd=5 (0x11) then rd=5 (0x22), rs=5 -> rs_busy=1; with REG_WB_FWD_EN rs_fwd_data=0x22, without it 0; rs=0 -> rs_busy=0.
REQ-040 Queue with 3 entries, assert flush together with in_valid -> count=0 next cycle, wr_en=0, busy flags clear.
REQ-041 Assert reset asynchronously with 2 entries queued and wb_stall=0 -> wr_en drops immediately, count=0, no further writes after release.
